// File: rtl/rep_string_agen_pkg.sv
// Shared definitions for the REP string address sequencer: FSM state
// encodings, element-size and REP-mode encodings, and the element size
// to byte-step lookup that the non-REP AG size muxing also uses.
// Optional feature macro: REP_AGEN_SEG_CHECK_EN (segment limit checking).
package rep_string_agen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_CMP = 3'd2,
        ST_FAULT    = 3'd3,
        ST_DONE     = 3'd4
    } agen_state_e;

    localparam logic [1:0] SIZE_B1 = 2'b00;
    localparam logic [1:0] SIZE_B2 = 2'b01;
    localparam logic [1:0] SIZE_B4 = 2'b10;
    localparam logic [1:0] SIZE_B8 = 2'b11;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_REP    = 2'b01;
    localparam logic [1:0] MODE_REPE   = 2'b10;
    localparam logic [1:0] MODE_REPNE  = 2'b11;

    // Byte count of one element for a given size encoding.
    function automatic logic [3:0] step_bytes(input logic [1:0] size);
        logic [3:0] bytes;
        case (size)
            SIZE_B1: bytes = 4'd1;
            SIZE_B2: bytes = 4'd2;
            SIZE_B4: bytes = 4'd4;
            SIZE_B8: bytes = 4'd8;
            default: bytes = 4'd1;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/rep_string_ptr.sv
// One pointer stream of the REP string sequencer: offset register with
// load and DF-signed stepping, segment base add, and (when
// REP_AGEN_SEG_CHECK_EN is defined) the inclusive segment limit compare.
module rep_string_ptr
    import rep_string_agen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step_en,
    input  logic [ADDR_W-1:0] ofs_init,
    input  logic [ADDR_W-1:0] base_init,
    input  logic [ADDR_W-1:0] limit_init,
    input  logic [1:0]        size,
    input  logic              df,
    output logic [ADDR_W-1:0] ofs,
    output logic [ADDR_W-1:0] lin_addr,
    output logic              limit_fault
);

    logic [ADDR_W-1:0] ofs_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] step_mag_s;
    logic [ADDR_W-1:0] ofs_next_s;

    assign step_mag_s = ADDR_W'(step_bytes(size));

    // Next offset: one element forward, or backward when DF is set (wraps).
    always_comb begin
        ofs_next_s = ofs_r;
        if (df) begin
            ofs_next_s = ofs_r - step_mag_s;
        end else begin
            ofs_next_s = ofs_r + step_mag_s;
        end
    end

    // Offset and segment base registers; load wins over stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofs_r  <= '0;
            base_r <= '0;
        end else if (load) begin
            ofs_r  <= ofs_init;
            base_r <= base_init;
        end else if (step_en) begin
            ofs_r  <= ofs_next_s;
        end
    end

    assign ofs      = ofs_r;
    assign lin_addr = base_r + ofs_r;

`ifdef REP_AGEN_SEG_CHECK_EN
    logic [ADDR_W-1:0] limit_r;
    logic [ADDR_W:0]   end_byte_s;

    // Inclusive segment limit latched with the rest of the configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_r <= '0;
        end else if (load) begin
            limit_r <= limit_init;
        end
    end

    // Last byte of the element, one bit wider so a carry out faults too.
    assign end_byte_s  = {1'b0, ofs_r} + (ADDR_W+1)'(step_bytes(size))
                         - {{ADDR_W{1'b0}}, 1'b1};
    assign limit_fault = (end_byte_s > {1'b0, limit_r});
`else
    logic unused_limit_s;
    assign unused_limit_s = ^limit_init;
    assign limit_fault    = 1'b0;
`endif

endmodule

// File: rtl/rep_string_agen.sv
// REP/REPE/REPNE string address sequencer for the AG stage. Walks
// NUM_STREAMS pointers per iteration, emits one linear address per stream
// over valid/ready, terminates on count or EX ZF feedback, and reports
// final offsets/count. Optional feature macro: REP_AGEN_SEG_CHECK_EN
// enables the per-stream segment limit check and the FAULT state.
module rep_string_agen
    import rep_string_agen_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 32,
    parameter int NUM_STREAMS = 2,
    parameter int SID_W       = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [NUM_STREAMS*ADDR_W-1:0] START_OFS,
    input  logic [NUM_STREAMS*ADDR_W-1:0] SEG_BASE,
    input  logic [NUM_STREAMS*ADDR_W-1:0] SEG_LIMIT,
    input  logic [CNT_W-1:0]              COUNT,
    input  logic [1:0]                    SIZE,
    input  logic                          DF,
    input  logic [1:0]                    REP_MODE,
    input  logic                          FLUSH,
    output logic                          ADDR_VALID,
    input  logic                          ADDR_READY,
    output logic [ADDR_W-1:0]             ADDR_OUT,
    output logic [SID_W-1:0]              ADDR_SID,
    output logic                          ADDR_LAST,
    input  logic                          CMP_VALID,
    input  logic                          CMP_ZF,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [NUM_STREAMS*ADDR_W-1:0] OFS_OUT,
    output logic [CNT_W-1:0]              CNT_OUT,
    output logic                          SEG_FAULT,
    output logic [SID_W-1:0]              FAULT_SID
);

    localparam logic [SID_W-1:0] LAST_SID = SID_W'(NUM_STREAMS - 1);

    agen_state_e       state_r;
    agen_state_e       state_n;
    logic [SID_W-1:0]  sid_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        size_r;
    logic [1:0]        mode_r;
    logic              df_r;
    logic              done_r;

    logic [CNT_W-1:0]  cnt_init_s;
    logic [CNT_W-1:0]  cnt_dec_s;
    logic              start_s;
    logic              addr_valid_s;
    logic              hs_s;
    logic              iter_end_s;
    logic              wait_mode_s;
    logic              cmp_stop_s;
    logic              fault_s;
    logic [ADDR_W-1:0] addr_mux_s;

    logic [ADDR_W-1:0]      lin_addr_s [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] lim_fault_s;

    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_ptr
        rep_string_ptr #(
            .ADDR_W (ADDR_W)
        ) u_ptr (
            .clk         (CLK),
            .rst_n       (RST),
            .load        (start_s),
            .step_en     (iter_end_s),
            .ofs_init    (START_OFS[g*ADDR_W +: ADDR_W]),
            .base_init   (SEG_BASE[g*ADDR_W +: ADDR_W]),
            .limit_init  (SEG_LIMIT[g*ADDR_W +: ADDR_W]),
            .size        (size_r),
            .df          (df_r),
            .ofs         (OFS_OUT[g*ADDR_W +: ADDR_W]),
            .lin_addr    (lin_addr_s[g]),
            .limit_fault (lim_fault_s[g])
        );
    end

    // Select the current stream's linear address and limit status.
    always_comb begin
        addr_mux_s = lin_addr_s[0];
        fault_s    = lim_fault_s[0];
        for (int i = 1; i < NUM_STREAMS; i++) begin
            addr_mux_s = (sid_r == SID_W'(i)) ? lin_addr_s[i]  : addr_mux_s;
            fault_s    = (sid_r == SID_W'(i)) ? lim_fault_s[i] : fault_s;
        end
    end

    assign cnt_init_s   = (REP_MODE == MODE_SINGLE) ? CNT_W'(1) : COUNT;
    assign cnt_dec_s    = cnt_r - CNT_W'(1);
    assign start_s      = (state_r == ST_IDLE) & START & ~FLUSH;
    assign addr_valid_s = (state_r == ST_ISSUE) & ~fault_s;
    assign hs_s         = addr_valid_s & ADDR_READY & ~FLUSH;
    assign iter_end_s   = hs_s & (sid_r == LAST_SID);
    assign wait_mode_s  = (mode_r == MODE_REPE) | (mode_r == MODE_REPNE);
    assign cmp_stop_s   = (cnt_r == '0)
                        | ((mode_r == MODE_REPE)  & ~CMP_ZF)
                        | ((mode_r == MODE_REPNE) &  CMP_ZF);

    // Next-state logic; FLUSH overrides every other event.
    always_comb begin
        state_n = state_r;
        if (FLUSH) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        if (cnt_init_s == '0) begin
                            state_n = ST_DONE;
                        end else begin
                            state_n = ST_ISSUE;
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (fault_s) begin
                        state_n = ST_FAULT;
                    end else if (iter_end_s) begin
                        if (wait_mode_s) begin
                            state_n = ST_WAIT_CMP;
                        end else if (cnt_dec_s == '0) begin
                            state_n = ST_DONE;
                        end else begin
                            state_n = ST_ISSUE;
                        end
                    end else begin
                        state_n = ST_ISSUE;
                    end
                end
                ST_WAIT_CMP: begin
                    if (CMP_VALID) begin
                        if (cmp_stop_s) begin
                            state_n = ST_DONE;
                        end else begin
                            state_n = ST_ISSUE;
                        end
                    end else begin
                        state_n = ST_WAIT_CMP;
                    end
                end
                ST_FAULT: state_n = ST_FAULT;
                ST_DONE:  state_n = ST_IDLE;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Iteration counter, stream index, latched config and DONE pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_r  <= '0;
            sid_r  <= '0;
            size_r <= SIZE_B1;
            mode_r <= MODE_SINGLE;
            df_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_n == ST_DONE);
            if (start_s) begin
                cnt_r  <= cnt_init_s;
                sid_r  <= '0;
                size_r <= SIZE;
                mode_r <= REP_MODE;
                df_r   <= DF;
            end else if (iter_end_s) begin
                cnt_r  <= cnt_dec_s;
                sid_r  <= '0;
            end else if (hs_s) begin
                sid_r  <= sid_r + SID_W'(1);
            end
        end
    end

`ifdef REP_AGEN_SEG_CHECK_EN
    logic             seg_fault_r;
    logic [SID_W-1:0] fault_sid_r;

    // Fault flag follows the FAULT state; the stream is captured on entry.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            seg_fault_r <= 1'b0;
            fault_sid_r <= '0;
        end else begin
            seg_fault_r <= (state_n == ST_FAULT);
            if ((state_r == ST_ISSUE) && (state_n == ST_FAULT)) begin
                fault_sid_r <= sid_r;
            end
        end
    end

    assign SEG_FAULT = seg_fault_r;
    assign FAULT_SID = fault_sid_r;
`else
    assign SEG_FAULT = 1'b0;
    assign FAULT_SID = '0;
`endif

    assign ADDR_VALID = addr_valid_s;
    assign ADDR_OUT   = addr_mux_s;
    assign ADDR_SID   = sid_r;
    assign ADDR_LAST  = addr_valid_s & (sid_r == LAST_SID) & (cnt_r == CNT_W'(1));
    assign BUSY       = (state_r != ST_IDLE);
    assign DONE       = done_r;
    assign CNT_OUT    = cnt_r;

endmodule

// File: tb/tb_rep_string_agen.sv
// Self-checking bench for rep_string_agen: a transaction-level reference
// model compared every cycle, directed scenarios with literal expectations,
// and a randomized soak. Honours REP_AGEN_SEG_CHECK_EN.
module tb_rep_string_agen;

    localparam int AW = 32;
    localparam int CW = 32;
    localparam int NS = 2;
    localparam int SW = 2;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_WAIT  = 2;
    localparam int P_FAULT = 3;
    localparam int P_DONE  = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [NS*AW-1:0] START_OFS = '0;
    logic [NS*AW-1:0] SEG_BASE = '0;
    logic [NS*AW-1:0] SEG_LIMIT = '1;
    logic [CW-1:0] COUNT = '0;
    logic [1:0]    SIZE = 2'b00;
    logic          DF = 1'b0;
    logic [1:0]    REP_MODE = 2'b00;
    logic          FLUSH = 1'b0;
    logic          ADDR_VALID;
    logic          ADDR_READY = 1'b0;
    logic [AW-1:0] ADDR_OUT;
    logic [SW-1:0] ADDR_SID;
    logic          ADDR_LAST;
    logic          CMP_VALID = 1'b0;
    logic          CMP_ZF = 1'b0;
    logic          BUSY;
    logic          DONE;
    logic [NS*AW-1:0] OFS_OUT;
    logic [CW-1:0] CNT_OUT;
    logic          SEG_FAULT;
    logic [SW-1:0] FAULT_SID;

    rep_string_agen #(
        .ADDR_W(AW), .CNT_W(CW), .NUM_STREAMS(NS), .SID_W(SW)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .START_OFS(START_OFS),
        .SEG_BASE(SEG_BASE), .SEG_LIMIT(SEG_LIMIT), .COUNT(COUNT),
        .SIZE(SIZE), .DF(DF), .REP_MODE(REP_MODE), .FLUSH(FLUSH),
        .ADDR_VALID(ADDR_VALID), .ADDR_READY(ADDR_READY),
        .ADDR_OUT(ADDR_OUT), .ADDR_SID(ADDR_SID), .ADDR_LAST(ADDR_LAST),
        .CMP_VALID(CMP_VALID), .CMP_ZF(CMP_ZF), .BUSY(BUSY), .DONE(DONE),
        .OFS_OUT(OFS_OUT), .CNT_OUT(CNT_OUT), .SEG_FAULT(SEG_FAULT),
        .FAULT_SID(FAULT_SID)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: programmer-visible sequencer state.
    int            m_phase;
    logic [AW-1:0] m_ofs  [NS];
    logic [AW-1:0] m_base [NS];
    logic [AW-1:0] m_lim  [NS];
    logic [CW-1:0] m_cnt;
    int            m_sid;
    int            m_bytes;
    bit            m_down;
    logic [1:0]    m_mode;
    bit            m_fault;
    int            m_fsid;

    logic [AW:0]   dut_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_would_fault(input int s);
`ifdef REP_AGEN_SEG_CHECK_EN
        longint unsigned last_byte;
        last_byte = {32'd0, m_ofs[s]} + 64'(m_bytes) - 64'd1;
        return last_byte > {32'd0, m_lim[s]};
`else
        return (s < 0);
`endif
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        for (int s = 0; s < NS; s++) begin
            m_ofs[s] = '0; m_base[s] = '0; m_lim[s] = '0;
        end
        m_cnt = '0; m_sid = 0; m_bytes = 1; m_down = 1'b0;
        m_mode = 2'b00; m_fault = 1'b0; m_fsid = 0;
    endtask

    // Advance the model by one clock using the inputs presented at the edge.
    task automatic model_update();
        if (!RST) begin
            model_reset();
        end else if (FLUSH) begin
            m_phase = P_IDLE;
            m_fault = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: if (START) begin
                    for (int s = 0; s < NS; s++) begin
                        m_ofs[s]  = START_OFS[s*AW +: AW];
                        m_base[s] = SEG_BASE[s*AW +: AW];
                        m_lim[s]  = SEG_LIMIT[s*AW +: AW];
                    end
                    m_bytes = 1 << SIZE;
                    m_down  = DF;
                    m_mode  = REP_MODE;
                    m_cnt   = (REP_MODE == 2'b00) ? CW'(1) : COUNT;
                    m_sid   = 0;
                    m_phase = (m_cnt == '0) ? P_DONE : P_ISSUE;
                end
                P_ISSUE: if (m_would_fault(m_sid)) begin
                    m_phase = P_FAULT; m_fault = 1'b1; m_fsid = m_sid;
                end else if (ADDR_READY) begin
                    if (m_sid < NS - 1) begin
                        m_sid++;
                    end else begin
                        for (int s = 0; s < NS; s++)
                            m_ofs[s] = m_down ? m_ofs[s] - AW'(m_bytes) : m_ofs[s] + AW'(m_bytes);
                        m_cnt = m_cnt - CW'(1);
                        m_sid = 0;
                        if (m_mode[1]) m_phase = P_WAIT;
                        else if (m_cnt == '0) m_phase = P_DONE;
                    end
                end
                P_WAIT: if (CMP_VALID) begin
                    if (m_cnt == '0 || (m_mode == 2'b10 && !CMP_ZF) || (m_mode == 2'b11 && CMP_ZF))
                        m_phase = P_DONE;
                    else
                        m_phase = P_ISSUE;
                end
                P_DONE: m_phase = P_IDLE;
                default: ;
            endcase
        end
    endtask

    task automatic compare_outputs();
        bit            ev;
        logic [AW-1:0] ea;
        logic [NS*AW-1:0] eo;
        ev = (m_phase == P_ISSUE) && !m_would_fault(m_sid);
        chk("addr_valid", 64'(ADDR_VALID), 64'(ev));
        if (ev) begin
            ea = m_base[m_sid] + m_ofs[m_sid];
            chk("addr_out", 64'(ADDR_OUT), 64'(ea));
            chk("addr_sid", 64'(ADDR_SID), 64'(m_sid));
            chk("addr_last", 64'(ADDR_LAST), 64'((m_sid == NS - 1) && (m_cnt == CW'(1))));
        end
        for (int s = 0; s < NS; s++) eo[s*AW +: AW] = m_ofs[s];
        chk("busy", 64'(BUSY), 64'(m_phase != P_IDLE));
        chk("done", 64'(DONE), 64'(m_phase == P_DONE));
        chk("ofs_out", 64'(OFS_OUT), 64'(eo));
        chk("cnt_out", 64'(CNT_OUT), 64'(m_cnt));
        chk("seg_fault", 64'(SEG_FAULT), 64'(m_fault));
        if (m_fault) chk("fault_sid", 64'(FAULT_SID), 64'(m_fsid));
    endtask

    // One clock: record an accepted address, step the model, compare.
    task automatic tick();
        if (RST && ADDR_VALID && ADDR_READY && !FLUSH) dut_q.push_back({ADDR_LAST, ADDR_OUT});
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        compare_outputs();
    endtask

    task automatic launch(input logic [AW-1:0] o0, o1, b0, b1, l0, l1,
                          input logic [CW-1:0] cnt, input logic [1:0] sz,
                          input logic d, input logic [1:0] md);
        START_OFS = {o1, o0}; SEG_BASE = {b1, b0}; SEG_LIMIT = {l1, l0};
        COUNT = cnt; SIZE = sz; DF = d; REP_MODE = md;
        dut_q.delete();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget && !DONE; i++) tick();
        chk("done_seen", 64'(DONE), 64'd1);
    endtask

    task automatic chk_q(input string nm, input int idx, input logic [AW:0] exp);
        if (idx < dut_q.size()) chk(nm, 64'(dut_q[idx]), 64'(exp));
    endtask

    logic [AW:0] exp_movs [6] = '{33'h0_0001_0100, 33'h0_0002_0200, 33'h0_0001_0104,
                                   33'h0_0002_0204, 33'h0_0001_0108, 33'h1_0002_0208};
    logic [AW:0] exp_cmps [6] = '{33'h0_0000_0100, 33'h0_0000_0200, 33'h0_0000_00FF,
                                   33'h0_0000_01FF, 33'h0_0000_00FE, 33'h0_0000_01FE};
    logic        zf_seq [3]   = '{1'b0, 1'b0, 1'b1};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        model_reset();
        #1 RST = 1'b0;
        @(negedge CLK);
        tick(); tick();
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_ofs", 64'(OFS_OUT), 64'd0);
        chk("rst_addr_out", 64'(ADDR_OUT), 64'd0);
        RST = 1'b1;
        tick();

        // REP MOVS dword, two streams, three iterations.
        ADDR_READY = 1'b1;
        launch(32'h100, 32'h200, 32'h10000, 32'h20000, '1, '1, 32'd3, 2'b10, 1'b0, 2'b01);
        run_until_done(30);
        chk("movs_naddr", 64'(dut_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) chk_q("movs_addr", i, exp_movs[i]);
        chk("movs_ofs", 64'(OFS_OUT), 64'h0000_020C_0000_010C);
        chk("movs_cnt", 64'(CNT_OUT), 64'd0);
        tick();

        // REPNE CMPS byte, decrementing, ZF = 0,0,1.
        launch(32'h100, 32'h200, 32'h0, 32'h0, '1, '1, 32'd5, 2'b00, 1'b1, 2'b11);
        k = 0;
        for (int i = 0; i < 40 && !DONE; i++) begin
            if (BUSY && !ADDR_VALID && k < 3) begin
                CMP_VALID = 1'b1; CMP_ZF = zf_seq[k]; k++;
            end else begin
                CMP_VALID = 1'b0;
            end
            tick();
        end
        CMP_VALID = 1'b0;
        chk("cmps_done", 64'(DONE), 64'd1);
        chk("cmps_ncmp", 64'(k), 64'd3);
        chk("cmps_naddr", 64'(dut_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) chk_q("cmps_addr", i, exp_cmps[i]);
        chk("cmps_cnt", 64'(CNT_OUT), 64'd2);
        chk("cmps_ofs", 64'(OFS_OUT), 64'h0000_01FD_0000_00FD);
        tick();

        // COUNT=0 under REP: straight to DONE, nothing issued.
        launch(32'h400, 32'h300, 32'h0, 32'h0, '1, '1, 32'd0, 2'b01, 1'b0, 2'b01);
        chk("cnt0_done", 64'(DONE), 64'd1);
        chk("cnt0_valid", 64'(ADDR_VALID), 64'd0);
        chk("cnt0_ofs", 64'(OFS_OUT), 64'h0000_0300_0000_0400);
        tick();
        chk("cnt0_idle", 64'(BUSY), 64'd0);
        chk("cnt0_naddr", 64'(dut_q.size()), 64'd0);

        // Stream-1 limit 0x203: second iteration faults on stream 1.
        launch(32'h100, 32'h200, 32'h10000, 32'h20000, 32'hFFFF_FFFF, 32'h203,
               32'd3, 2'b10, 1'b0, 2'b01);
`ifdef REP_AGEN_SEG_CHECK_EN
        for (int i = 0; i < 30 && !SEG_FAULT; i++) tick();
        chk("lim_fault", 64'(SEG_FAULT), 64'd1);
        chk("lim_sid", 64'(FAULT_SID), 64'd1);
        chk("lim_naddr", 64'(dut_q.size()), 64'd3);
        chk("lim_ofs", 64'(OFS_OUT), 64'h0000_0204_0000_0104);
        chk("lim_cnt", 64'(CNT_OUT), 64'd2);
        START = 1'b1;
        tick(); tick();
        START = 1'b0;
        chk("lim_hold", 64'(BUSY), 64'd1);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("lim_flush_idle", 64'(BUSY), 64'd0);
        chk("lim_flush_fault", 64'(SEG_FAULT), 64'd0);
        chk("lim_flush_ofs", 64'(OFS_OUT), 64'h0000_0204_0000_0104);
`else
        run_until_done(30);
        chk("lim_naddr", 64'(dut_q.size()), 64'd6);
        chk("lim_fault", 64'(SEG_FAULT), 64'd0);
`endif
        tick();

        // ADDR_READY low mid-iteration, then FLUSH with a same-cycle handshake.
        ADDR_READY = 1'b1;
        launch(32'h40, 32'h80, 32'h0, 32'h0, '1, '1, 32'd4, 2'b00, 1'b0, 2'b01);
        tick();
        ADDR_READY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_addr", 64'(ADDR_OUT), 64'h80);
            chk("stall_cnt", 64'(CNT_OUT), 64'd4);
        end
        FLUSH = 1'b1; ADDR_READY = 1'b1;
        tick();
        FLUSH = 1'b0; ADDR_READY = 1'b0;
        chk("flush_idle", 64'(BUSY), 64'd0);
        chk("flush_cnt", 64'(CNT_OUT), 64'd4);
        chk("flush_ofs", 64'(OFS_OUT), 64'h0000_0080_0000_0040);
        chk("flush_naddr", 64'(dut_q.size()), 64'd1);

        // Asynchronous reset in the middle of ISSUE, then a clean rerun.
        launch(32'h100, 32'h200, 32'h10000, 32'h20000, '1, '1, 32'd3, 2'b10, 1'b0, 2'b01);
        tick();
        #2 RST = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 64'(ADDR_VALID), 64'd0);
        chk("arst_addr", 64'(ADDR_OUT), 64'd0);
        chk("arst_busy", 64'(BUSY), 64'd0);
        chk("arst_ofs", 64'(OFS_OUT), 64'd0);
        chk("arst_cnt", 64'(CNT_OUT), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        ADDR_READY = 1'b1;
        launch(32'h100, 32'h200, 32'h10000, 32'h20000, '1, '1, 32'd3, 2'b10, 1'b0, 2'b01);
        run_until_done(30);
        chk("rerun_naddr", 64'(dut_q.size()), 64'd6);
        chk_q("rerun_last", 5, exp_movs[5]);
        tick();

        // Randomized soak; configuration inputs change every cycle.
        for (int c = 0; c < 2500; c++) begin
            START      = ($urandom_range(0, 5) == 0);
            FLUSH      = ($urandom_range(0, 39) == 0);
            ADDR_READY = ($urandom_range(0, 9) < 7);
            CMP_VALID  = ($urandom_range(0, 3) == 0);
            CMP_ZF     = 1'($urandom_range(0, 1));
            for (int s = 0; s < NS; s++) begin
                logic [AW-1:0] o;
                o = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + AW'($urandom_range(0, 15)) : AW'($urandom);
                START_OFS[s*AW +: AW] = o;
                SEG_BASE[s*AW +: AW]  = AW'($urandom);
                SEG_LIMIT[s*AW +: AW] = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF
                                        : o + AW'($urandom_range(0, 40));
            end
            COUNT    = CW'($urandom_range(0, 6));
            SIZE     = 2'($urandom_range(0, 3));
            DF       = 1'($urandom_range(0, 1));
            REP_MODE = 2'($urandom_range(0, 3));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
